imem_loader: RTL and testbench

Boot-time program loader that writes the processor's instruction memory. It accepts a framed little-endian byte stream over a valid/ready handshake, assembles 32-bit instruction words, and drives the instruction-memory write port. It holds the processor core in reset until the whole image is written and the checksum passes. It sits beside the pipelined core at the top level and feeds the core's `i_mem_wr_en` / `i_mem_wr_data` write path.

---
 rtl/imem_loader.sv | 151 +++++++++++++++
 tb/tb_imem_loader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader: framed byte stream to instruction-memory writes
module imem_loader #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    MAX_WORDS  = 256,
    parameter logic [7:0]            SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  reload,
    output logic                  i_mem_wr_en,
    output logic [ADDR_WIDTH-1:0] i_mem_wr_addr,
    output logic [31:0]           i_mem_wr_data,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    state_t      state;
    logic [15:0] len;
    logic [15:0] word_cnt;
    logic [1:0]  byte_cnt;
    logic [7:0]  sum;
    logic [23:0] word_buf;
    logic        fire;
    logic [15:0] len_next;

    assign fire     = in_valid && in_ready;
    assign len_next = {in_data, len[7:0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_IDLE;
            in_ready      <= 1'b0;
            i_mem_wr_en   <= 1'b0;
            i_mem_wr_addr <= BASE_ADDR;
            i_mem_wr_data <= '0;
            cpu_rst       <= 1'b1;
            done          <= 1'b0;
            err           <= 1'b0;
            len           <= '0;
            word_cnt      <= '0;
            byte_cnt      <= '0;
            sum           <= '0;
            word_buf      <= '0;
        end else begin
            i_mem_wr_en <= 1'b0;
            in_ready    <= 1'b1;
            unique case (state)
                S_IDLE: begin
                    if (fire && in_data == SYNC_BYTE) begin
                        state    <= S_LEN_LO;
                        sum      <= '0;
                        byte_cnt <= '0;
                        word_cnt <= '0;
                    end
                end
                S_LEN_LO: begin
                    if (fire) begin
                        len[7:0] <= in_data;
                        state    <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (fire) begin
                        len[15:8] <= in_data;
                        if (len_next > MAX_LEN) begin
                            state    <= S_ERR;
                            err      <= 1'b1;
                            in_ready <= 1'b0;
                        end else if (len_next == 16'd0) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (fire) begin
                        sum      <= sum + in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            // word_buf holds {b2,b1,b0}; the 4th byte completes the word
                            i_mem_wr_en   <= 1'b1;
                            i_mem_wr_addr <= BASE_ADDR + ADDR_WIDTH'({word_cnt, 2'b00});
                            i_mem_wr_data <= {in_data, word_buf};
                            word_cnt      <= word_cnt + 16'd1;
                            if (word_cnt == len - 16'd1) begin
                                state <= S_CSUM;
                            end
                        end else begin
                            word_buf <= {in_data, word_buf[23:8]};
                        end
                    end
                end
                S_CSUM: begin
                    if (fire) begin
                        in_ready <= 1'b0;
                        if (in_data == sum) begin
                            state   <= S_DONE;
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (reload) begin
                        state    <= S_IDLE;
                        done     <= 1'b0;
                        cpu_rst  <= 1'b1;
                        word_cnt <= '0;
                        byte_cnt <= '0;
                        sum      <= '0;
                    end else begin
                        in_ready <= 1'b0;
                    end
                end
                S_ERR: begin
                    if (reload) begin
                        state <= S_IDLE;
                        err   <= 1'b0;
                    end else begin
                        in_ready <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        reload = 1'b0;
    logic        i_mem_wr_en;
    logic [31:0] i_mem_wr_addr;
    logic [31:0] i_mem_wr_data;
    logic        cpu_rst;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic [7:0]  seq[$];

    imem_loader dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .reload        (reload),
        .i_mem_wr_en   (i_mem_wr_en),
        .i_mem_wr_addr (i_mem_wr_addr),
        .i_mem_wr_data (i_mem_wr_data),
        .cpu_rst       (cpu_rst),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (i_mem_wr_en === 1'b1) begin
            wa.push_back(i_mem_wr_addr);
            wd.push_back(i_mem_wr_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int cnt;
        cnt      = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
        end
        if (cnt == 20) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] s[$], input bit gaps);
        foreach (s[i]) begin
            send_byte(s[i]);
            if (gaps && (i % 3 == 1)) repeat ($urandom_range(1, 3)) tick();
        end
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
    endtask

    initial begin
        // reset state
        repeat (2) tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_wr_en", {31'd0, i_mem_wr_en}, 32'd0);
        chk("rst_wr_addr", i_mem_wr_addr, 32'h0);
        chk("rst_wr_data", i_mem_wr_data, 32'h0);
        chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);
        rst = 1'b1;
        tick();
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

        // scenario 1: two words, full rate, checksum 13+93+10 = B6
        clear_log();
        seq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00};
        send_seq(seq, 1'b0);
        send_byte(8'h00);
        chk("s1_wr_en_latency", {31'd0, i_mem_wr_en}, 32'd1);
        chk("s1_wr_addr0_live", i_mem_wr_addr, 32'h0);
        chk("s1_wr_data0_live", i_mem_wr_data, 32'h0000_0013);
        seq = '{8'h93, 8'h00, 8'h10, 8'h00};
        send_seq(seq, 1'b0);
        chk("s1_done_before_csum", {31'd0, done}, 32'd0);
        send_byte(8'hB6);
        chk("s1_done", {31'd0, done}, 32'd1);
        chk("s1_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        chk("s1_err", {31'd0, err}, 32'd0);
        chk("s1_nwrites", wa.size(), 32'd2);
        chk("s1_addr1", wa[1], 32'h4);
        chk("s1_data1", wd[1], 32'h0010_0093);
        pulse_reload();
        chk("s1_reload_done", {31'd0, done}, 32'd0);
        chk("s1_reload_cpu_rst", {31'd0, cpu_rst}, 32'd1);

        // scenario 2: bad checksum
        clear_log();
        seq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00, 8'hC8};
        send_seq(seq, 1'b0);
        chk("s2_err", {31'd0, err}, 32'd1);
        chk("s2_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("s2_in_ready", {31'd0, in_ready}, 32'd0);
        chk("s2_nwrites", wa.size(), 32'd2);
        pulse_reload();
        chk("s2_reload_err", {31'd0, err}, 32'd0);
        chk("s2_reload_ready", {31'd0, in_ready}, 32'd1);

        // scenario 3: len 257 too large, then zero-length image
        clear_log();
        seq = '{8'hA5, 8'h01, 8'h01};
        send_seq(seq, 1'b0);
        chk("s3_len_err", {31'd0, err}, 32'd1);
        chk("s3_len_nwrites", wa.size(), 32'd0);
        pulse_reload();
        seq = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_seq(seq, 1'b0);
        chk("s3_zero_done", {31'd0, done}, 32'd1);
        chk("s3_zero_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        chk("s3_zero_nwrites", wa.size(), 32'd0);
        pulse_reload();

        // scenario 4: garbage prefix and valid gaps
        clear_log();
        seq = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
        send_seq(seq, 1'b1);
        chk("s4_done", {31'd0, done}, 32'd1);
        chk("s4_nwrites", wa.size(), 32'd2);
        chk("s4_addr0", wa[0], 32'h0);
        chk("s4_data0", wd[0], 32'h0000_0013);
        chk("s4_addr1", wa[1], 32'h4);
        chk("s4_data1", wd[1], 32'h0010_0093);
        pulse_reload();

        // scenario 5: reset mid-word, then fresh frame
        clear_log();
        seq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00};
        send_seq(seq, 1'b0);
        rst = 1'b0;
        tick();
        chk("s5_rst_ready", {31'd0, in_ready}, 32'd0);
        chk("s5_rst_addr", i_mem_wr_addr, 32'h0);
        rst = 1'b1;
        tick();
        chk("s5_abort_nwrites", wa.size(), 32'd0);
        seq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
        send_seq(seq, 1'b0);
        chk("s5_done", {31'd0, done}, 32'd1);
        chk("s5_nwrites", wa.size(), 32'd2);
        chk("s5_addr0", wa[0], 32'h0);
        chk("s5_data1", wd[1], 32'h0010_0093);

        // scenario 6: bytes offered in DONE are not consumed
        clear_log();
        in_data  = 8'hA5;
        in_valid = 1'b1;
        repeat (3) tick();
        chk("s6_in_ready", {31'd0, in_ready}, 32'd0);
        chk("s6_done_hold", {31'd0, done}, 32'd1);
        chk("s6_cpu_rst_hold", {31'd0, cpu_rst}, 32'd0);
        chk("s6_nwrites", wa.size(), 32'd0);
        in_valid = 1'b0;
        pulse_reload();
        // EF+BE+AD+DE mod 256 = 38
        seq = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h38};
        send_seq(seq, 1'b0);
        chk("s6_done", {31'd0, done}, 32'd1);
        chk("s6_nwrites_after", wa.size(), 32'd1);
        chk("s6_addr0", wa[0], 32'h0);
        chk("s6_data0", wd[0], 32'hDEAD_BEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
